div_clk_sched: RTL and testbench



---
 rtl/div_clk_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/div_clk_sched.sv | 132 +++++++++++++
 tb/tb_div_clk_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_clk_pkg.sv
// Shared types and helpers for the divided-clock scheduler.
package div_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

  // High-phase length of an N-cycle period; 33 bits so N = 2^32-1 cannot wrap.
  function automatic logic [32:0] high_len(input logic [32:0] n);
    return (n + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the pointer; the pointer moves past the granted requester on accept.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;
  logic          found_hi;
  logic          found_any;

  always_comb begin
    gidx      = '0;
    found_hi  = 1'b0;
    found_any = 1'b0;
    // Descending scans leave the lowest qualifying index in gidx.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_i[i] && (i >= int'(ptr_q))) begin
        gidx     = PW'(i);
        found_hi = 1'b1;
      end
    end
    if (!found_hi) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (valid_i[i]) begin
          gidx      = PW'(i);
          found_any = 1'b1;
        end
      end
    end
    grant_o = '0;
    if (found_hi || found_any) grant_o[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/div_clk_sched.sv
// Glitch-free programmable clock divider with arbitrated ratio updates.
//   state | meaning
//   IDLE  | stopped, counter 0, div_clk low
//   RUN   | periods running, en high
//   DRAIN | en low, finishing the current period
module div_clk_sched import div_clk_pkg::*; #(
  parameter int CNT_W       = 16,
  parameter int NREQ        = 2,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*CNT_W-1:0] req_div_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  div_clk_o,
  output logic                  div_tick_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      cur_div_o,
  output logic                  cfg_applied_o,
  output logic                  cfg_err_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cur_div_q, cur_div_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic               pend_valid_q, pend_valid_d;
  logic               div_clk_q, div_clk_d;
  logic               div_tick_q, div_tick_d;
  logic               busy_q, busy_d;
  logic               applied_q, applied_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    grant;
  logic [CNT_W-1:0]   acc_div;
  logic               accept, last, apply;

  assign accept      = !pend_valid_q && (|req_valid_i);
  assign req_ready_o = pend_valid_q ? '0 : grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (req_valid_i),
    .accept_i (accept),
    .grant_o  (grant)
  );

  always_comb begin
    acc_div = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) acc_div = req_div_i[i*CNT_W +: CNT_W];
    end

    last  = (state_q != IDLE) && (cnt_q == cur_div_q - CNT_W'(1));
    apply = pend_valid_q && (last || (state_q == IDLE));

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = en_i ? RUN : IDLE;
      end
      default: begin
        if (last) begin
          cnt_d   = '0;
          state_d = en_i ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en_i ? RUN : DRAIN;
        end
      end
    endcase

    cur_div_d    = apply ? pend_div_q : cur_div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    err_d        = 1'b0;
    if (apply) begin
      pend_valid_d = 1'b0;
    end else if (accept) begin
      if (int'(acc_div) < MIN_DIV) begin
        err_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_div_d   = acc_div;
      end
    end
    applied_d = apply;

    busy_d     = (state_d != IDLE);
    div_clk_d  = busy_d && (33'(cnt_d) < high_len(33'(cur_div_d)));
    div_tick_d = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= CNT_W'(DIV_DEFAULT);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      div_clk_q    <= 1'b0;
      div_tick_q   <= 1'b0;
      busy_q       <= 1'b0;
      applied_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      div_clk_q    <= div_clk_d;
      div_tick_q   <= div_tick_d;
      busy_q       <= busy_d;
      applied_q    <= applied_d;
      err_q        <= err_d;
    end
  end

  assign div_clk_o     = div_clk_q;
  assign div_tick_o    = div_tick_q;
  assign busy_o        = busy_q;
  assign cur_div_o     = cur_div_q;
  assign cfg_applied_o = applied_q;
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_div_clk_sched.sv
// Scoreboard bench for div_clk_sched: a period-level reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_div_clk_sched;

  localparam int CNT_W       = 4;
  localparam int NREQ        = 2;
  localparam int DIV_DEFAULT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en_i = 1'b0;
  logic [NREQ-1:0]       req_valid_i = '0;
  logic [NREQ*CNT_W-1:0] req_div_i = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic                  div_clk_o, div_tick_o, busy_o, cfg_applied_o, cfg_err_o;
  logic [CNT_W-1:0]      cur_div_o;

  div_clk_sched #(.CNT_W(CNT_W), .NREQ(NREQ), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .req_valid_i   (req_valid_i),
    .req_div_i     (req_div_i),
    .req_ready_o   (req_ready_o),
    .div_clk_o     (div_clk_o),
    .div_tick_o    (div_tick_o),
    .busy_o        (busy_o),
    .cur_div_o     (cur_div_o),
    .cfg_applied_o (cfg_applied_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dclk, tick, busy, app, err;
    int cur, ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit t_rst = 1'b0;
  bit t_en  = 1'b0;
  bit rv[NREQ];
  int rd[NREQ];

  // Reference model: a running flag, position in the period, ratio, one slot.
  bit m_active, m_clk, m_tick, m_busy, m_app, m_err;
  int m_pos, m_n, m_pend, m_ptr, m_grant;

  task automatic m_reset();
    m_active = 0; m_pos = 0; m_n = DIV_DEFAULT; m_pend = -1; m_ptr = 0;
    m_clk = 0; m_tick = 0; m_busy = 0; m_app = 0; m_err = 0;
  endtask

  task automatic m_comb();
    m_grant = -1;
    if (m_pend < 0)
      for (int k = NREQ - 1; k >= 0; k--)
        if (rv[(m_ptr + k) % NREQ]) m_grant = (m_ptr + k) % NREQ;
  endtask

  task automatic m_update();
    bit last, apply;
    int nn;
    last  = m_active && (m_pos == m_n - 1);
    apply = (m_pend >= 0) && (last || !m_active);
    nn    = apply ? m_pend : m_n;
    if (!m_active) begin
      if (t_en) begin m_active = 1; m_pos = 0; end
    end else if (last) begin
      m_pos = 0; m_active = t_en;
    end else begin
      m_pos++;
    end
    m_app = apply;
    if (apply) m_pend = -1;
    m_err = 0;
    if (m_grant >= 0) begin
      m_ptr = (m_grant + 1) % NREQ;
      if (rd[m_grant] < 2) m_err = 1;
      else m_pend = rd[m_grant];
      rv[m_grant] = 0;
    end
    m_n    = nn;
    m_clk  = m_active && (m_pos < (m_n + 1) / 2);
    m_tick = m_active && (m_pos == 0);
    m_busy = m_active;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!t_rst) for (int i = 0; i < NREQ; i++) rv[i] = 0;
    rst_n = t_rst;
    en_i  = t_en;
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i] = rv[i];
      req_div_i[i*CNT_W +: CNT_W] = CNT_W'(rd[i]);
    end
    if (!t_rst) m_reset();
    m_comb();
    e.dclk = m_clk; e.tick = m_tick; e.busy = m_busy; e.app = m_app; e.err = m_err;
    e.cur = m_n;
    e.ready = (m_grant >= 0) ? (1 << m_grant) : 0;
    exp_q.push_back(e);
    @(posedge clk);
    if (t_rst) m_update();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < 100 && !(m_active && m_pos == p); k++) step();
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_clk", int'(div_clk_o), int'(e.dclk));
        chk("div_tick", int'(div_tick_o), int'(e.tick));
        chk("busy", int'(busy_o), int'(e.busy));
        chk("cur_div", int'(cur_div_o), e.cur);
        chk("cfg_applied", int'(cfg_applied_o), int'(e.app));
        chk("cfg_err", int'(cfg_err_o), int'(e.err));
        chk("req_ready", int'(req_ready_o), e.ready);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin rv[i] = 0; rd[i] = 0; end
    m_reset();
    t_rst = 0; run(3);
    t_rst = 1; run(3);
    // default ratio from the cycle after en
    t_en = 1; run(12);
    // requester 0 asks for 5 while the counter is at 1
    wait_pos(1); rv[0] = 1; rd[0] = 5; run(16);
    // two requesters at once
    rv[0] = 1; rd[0] = 6; rv[1] = 1; rd[1] = 3; run(30);
    // invalid ratio
    rv[1] = 1; rd[1] = 1; run(6);
    // request in the last cycle of a period, then max ratio
    wait_pos(m_n - 1); rv[0] = 1; rd[0] = 5; run(12);
    rv[1] = 1; rd[1] = 15; run(34);
    // drain to idle, then drain with re-enable
    rv[0] = 1; rd[0] = 5; run(12);
    wait_pos(1); t_en = 0; run(8);
    t_en = 1; wait_pos(1); t_en = 0; run(2); t_en = 1; run(12);
    // en falls in the apply cycle; equal-ratio request
    rv[0] = 1; rd[0] = 5; wait_pos(m_n - 1); t_en = 0; run(4);
    rv[1] = 1; rd[1] = 5; t_en = 1; run(14);
    // reset mid-period with a request pending
    rv[0] = 1; rd[0] = 7; wait_pos(2); t_rst = 0; run(1); t_rst = 1; run(10);
    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 19) == 0) t_en = !t_en;
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 9) == 0) begin
          rv[i] = 1; rd[i] = int'($urandom_range(0, 15));
        end
      if ($urandom_range(0, 599) == 0) begin t_rst = 0; step(); t_rst = 1; end
      step();
    end
    run(2);
    @(negedge clk); #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
